// File: rtl/imuldiv_div_requester_pkg.sv
// Shared constants and helpers for the divide requester: divider response
// field positions, function codes and the divreq message packing.
package imuldiv_div_requester_pkg;

    localparam int REM_HI = 63;
    localparam int REM_LO = 32;
    localparam int QUO_HI = 31;
    localparam int QUO_LO = 0;

    localparam logic FN_SIGNED   = 1'b1;
    localparam logic FN_UNSIGNED = 1'b0;

    localparam int DIVREQ_W = 65;

    // divreq message is packed as {fn, a, b}
    function automatic logic [DIVREQ_W-1:0] pack_divreq(
        input logic        fn,
        input logic [31:0] a,
        input logic [31:0] b
    );
        return {fn, a, b};
    endfunction

    function automatic logic [31:0] select_result(
        input logic [63:0] result,
        input logic        rem
    );
        logic [31:0] sel;
        if (rem) begin
            sel = result[REM_HI:REM_LO];
        end else begin
            sel = result[QUO_HI:QUO_LO];
        end
        return sel;
    endfunction

endpackage

// File: rtl/imuldiv_div_requester_tag_fifo.sv
// Parameterised-depth synchronous FIFO holding {rem, tag} for each divide
// request in flight; count/full/empty exposed for issue throttling.
module imuldiv_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    import imuldiv_div_requester_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == {CNT_W{1'b0}});
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when a pop frees the slot this cycle
    assign do_push_s = push && (!full || pop);
    assign do_pop_s  = pop && !empty;

    // Next-state for pointers, occupancy and storage
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/imuldiv_div_requester.sv
// Pipeline-side client of the iterative divider: registers tagged commands,
// issues divreq, tracks in-flight tags and retires selected results.
module imuldiv_div_requester
    import imuldiv_div_requester_pkg::*;
#(
    parameter int TAG_W   = 5,
    parameter int MAX_OUT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_val,
    output logic             cmd_rdy,
    input  logic             cmd_fn,
    input  logic             cmd_rem,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             divreq_msg_fn,
    output logic [31:0]      divreq_msg_a,
    output logic [31:0]      divreq_msg_b,
    output logic             divreq_val,
    input  logic             divreq_rdy,
    input  logic [63:0]      divresp_msg_result,
    input  logic             divresp_val,
    output logic             divresp_rdy,
    output logic             wb_val,
    input  logic             wb_rdy,
    output logic [31:0]      wb_data,
    output logic [TAG_W-1:0] wb_tag,
    output logic             err
);

    localparam int CNT_W = $clog2(MAX_OUT) + 1;
    localparam int FW    = TAG_W + 1;

    logic             req_full_q, req_full_d;
    logic             req_fn_q,   req_fn_d;
    logic             req_rem_q,  req_rem_d;
    logic [31:0]      req_a_q,    req_a_d;
    logic [31:0]      req_b_q,    req_b_d;
    logic [TAG_W-1:0] req_tag_q,  req_tag_d;

    logic             wb_full_q,  wb_full_d;
    logic [31:0]      wb_data_q,  wb_data_d;
    logic [TAG_W-1:0] wb_tag_q,   wb_tag_d;
    logic             err_q,      err_d;

    logic             cmd_fire_s;
    logic             req_fire_s;
    logic             resp_fire_s;
    logic             fifo_can_push_s;
    logic             divreq_val_s;
    logic [FW-1:0]    fifo_head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;

    // Issue is throttled only by registered state, so cmd_val never reaches divreq_val
    assign divreq_val_s    = req_full_q && (fifo_count_s < CNT_W'(MAX_OUT));
    assign req_fire_s      = divreq_val_s && divreq_rdy;
    assign resp_fire_s     = divresp_val && divresp_rdy;
    assign fifo_can_push_s = (fifo_count_s < CNT_W'(MAX_OUT)) || resp_fire_s;
    assign cmd_rdy         = !req_full_q || (req_fire_s && fifo_can_push_s);
    assign cmd_fire_s      = cmd_val && cmd_rdy;
    assign divresp_rdy     = !wb_full_q || wb_rdy;

    assign divreq_val = divreq_val_s;
    assign {divreq_msg_fn, divreq_msg_a, divreq_msg_b} = pack_divreq(req_fn_q, req_a_q, req_b_q);

    assign wb_val  = wb_full_q;
    assign wb_data = wb_data_q;
    assign wb_tag  = wb_tag_q;
    assign err     = err_q;

    imuldiv_tag_fifo #(
        .DEPTH (MAX_OUT),
        .W     (FW)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_fire_s),
        .push_data ({req_rem_q, req_tag_q}),
        .pop       (resp_fire_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Request register: load on command fire, drain on request fire
    always_comb begin
        req_full_d = req_full_q;
        req_fn_d   = req_fn_q;
        req_rem_d  = req_rem_q;
        req_a_d    = req_a_q;
        req_b_d    = req_b_q;
        req_tag_d  = req_tag_q;
        if (cmd_fire_s) begin
            req_full_d = 1'b1;
            req_fn_d   = cmd_fn;
            req_rem_d  = cmd_rem;
            req_a_d    = cmd_a;
            req_b_d    = cmd_b;
            req_tag_d  = cmd_tag;
        end else if (req_fire_s) begin
            req_full_d = 1'b0;
        end else begin
            req_full_d = req_full_q;
        end
    end

    // Writeback register; an unexpected response retires tag 0 with the quotient
    always_comb begin
        wb_full_d = wb_full_q;
        wb_data_d = wb_data_q;
        wb_tag_d  = wb_tag_q;
        err_d     = err_q;
        if (resp_fire_s) begin
            wb_full_d = 1'b1;
            if (fifo_empty_s) begin
                wb_data_d = divresp_msg_result[QUO_HI:QUO_LO];
                wb_tag_d  = {TAG_W{1'b0}};
                err_d     = 1'b1;
            end else begin
                wb_data_d = select_result(divresp_msg_result, fifo_head_s[FW-1]);
                wb_tag_d  = fifo_head_s[TAG_W-1:0];
            end
        end else if (wb_full_q && wb_rdy) begin
            wb_full_d = 1'b0;
        end else begin
            wb_full_d = wb_full_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_full_q <= 1'b0;
            req_fn_q   <= FN_UNSIGNED;
            req_rem_q  <= 1'b0;
            req_a_q    <= 32'h0000_0000;
            req_b_q    <= 32'h0000_0000;
            req_tag_q  <= {TAG_W{1'b0}};
            wb_full_q  <= 1'b0;
            wb_data_q  <= 32'h0000_0000;
            wb_tag_q   <= {TAG_W{1'b0}};
            err_q      <= 1'b0;
        end else begin
            req_full_q <= req_full_d;
            req_fn_q   <= req_fn_d;
            req_rem_q  <= req_rem_d;
            req_a_q    <= req_a_d;
            req_b_q    <= req_b_d;
            req_tag_q  <= req_tag_d;
            wb_full_q  <= wb_full_d;
            wb_data_q  <= wb_data_d;
            wb_tag_q   <= wb_tag_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_imuldiv_div_requester.sv
// Directed bench for imuldiv_div_requester: table of single-command vectors
// plus hand-written sequences for backpressure, stalls, err and reset.
module tb_imuldiv_div_requester;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_val, cmd_rdy, cmd_fn, cmd_rem;
    logic [31:0] cmd_a, cmd_b;
    logic [4:0]  cmd_tag;
    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a, divreq_msg_b;
    logic        divreq_val, divreq_rdy;
    logic [63:0] divresp_msg_result;
    logic        divresp_val, divresp_rdy;
    logic        wb_val, wb_rdy;
    logic [31:0] wb_data;
    logic [4:0]  wb_tag;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        fn;
        logic        rem;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [63:0] result;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    imuldiv_div_requester #(.TAG_W(5), .MAX_OUT(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .cmd_val            (cmd_val),
        .cmd_rdy            (cmd_rdy),
        .cmd_fn             (cmd_fn),
        .cmd_rem            (cmd_rem),
        .cmd_a              (cmd_a),
        .cmd_b              (cmd_b),
        .cmd_tag            (cmd_tag),
        .divreq_msg_fn      (divreq_msg_fn),
        .divreq_msg_a       (divreq_msg_a),
        .divreq_msg_b       (divreq_msg_b),
        .divreq_val         (divreq_val),
        .divreq_rdy         (divreq_rdy),
        .divresp_msg_result (divresp_msg_result),
        .divresp_val        (divresp_val),
        .divresp_rdy        (divresp_rdy),
        .wb_val             (wb_val),
        .wb_rdy             (wb_rdy),
        .wb_data            (wb_data),
        .wb_tag             (wb_tag),
        .err                (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic fn, input logic rem, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] tag);
        cmd_fn = fn; cmd_rem = rem; cmd_a = a; cmd_b = b; cmd_tag = tag;
        cmd_val = 1'b1;
        #1;
        chk("send_cmd_rdy", 65'(cmd_rdy), 65'd1);
        tick();
        cmd_val = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        cmd_fn = v.fn; cmd_rem = v.rem; cmd_a = v.a; cmd_b = v.b; cmd_tag = v.tag;
        cmd_val = 1'b1;
        #1;
        chk("vec_cmd_rdy", 65'(cmd_rdy), 65'd1);
        chk("vec_no_comb_divreq", 65'(divreq_val), 65'd0);
        tick();
        cmd_val = 1'b0;
        #1;
        chk("vec_divreq_val", 65'(divreq_val), 65'd1);
        chk("vec_divreq_msg", {divreq_msg_fn, divreq_msg_a, divreq_msg_b}, {v.fn, v.a, v.b});
        tick();
        chk("vec_divreq_hold", {divreq_msg_fn, divreq_msg_a, divreq_msg_b}, {v.fn, v.a, v.b});
        chk("vec_divreq_val_hold", 65'(divreq_val), 65'd1);
        divreq_rdy = 1'b1;
        tick();
        divreq_rdy = 1'b0;
        #1;
        chk("vec_divreq_done", 65'(divreq_val), 65'd0);
        divresp_val = 1'b1;
        divresp_msg_result = v.result;
        #1;
        chk("vec_divresp_rdy", 65'(divresp_rdy), 65'd1);
        tick();
        divresp_val = 1'b0;
        chk("vec_wb_val", 65'(wb_val), 65'd1);
        chk("vec_wb_data", 65'(wb_data), 65'(v.exp_data));
        chk("vec_wb_tag", 65'(wb_tag), 65'(v.tag));
        tick();
        chk("vec_wb_retired", 65'(wb_val), 65'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0222, 32'h0000_002a, 5'd3,  64'h0000_0000_0000_000d, 32'h0000_000d};
        vecs[1] = '{1'b1, 1'b1, 32'hdead_beef, 32'h0000_beef, 5'd9,  64'hffff_da72_ffff_d353, 32'hffff_da72};
        vecs[2] = '{1'b0, 1'b0, 32'hfdec_2897, 32'h0000_2266, 5'd17, 64'h0000_1d49_0007_61bd, 32'h0007_61bd};
        vecs[3] = '{1'b0, 1'b1, 32'd100,       32'd7,         5'd31, 64'h0000_0002_0000_000e, 32'h0000_0002};
        vecs[4] = '{1'b1, 1'b0, 32'hffff_fff9, 32'd2,         5'd0,  64'hffff_ffff_ffff_fffd, 32'hffff_fffd};
        vecs[5] = '{1'b0, 1'b1, 32'd5,         32'd0,         5'd22, 64'h0000_0005_ffff_ffff, 32'h0000_0005};

        reset = 1'b1;
        cmd_val = 1'b0; cmd_fn = 1'b0; cmd_rem = 1'b0;
        cmd_a = 32'h0; cmd_b = 32'h0; cmd_tag = 5'd0;
        divreq_rdy = 1'b0; divresp_val = 1'b0; divresp_msg_result = 64'h0;
        wb_rdy = 1'b1;
        #3;
        chk("rst_divreq_val", 65'(divreq_val), 65'd0);
        chk("rst_wb_val", 65'(wb_val), 65'd0);
        chk("rst_err", 65'(err), 65'd0);
        chk("rst_cmd_rdy", 65'(cmd_rdy), 65'd1);
        chk("rst_divresp_rdy", 65'(divresp_rdy), 65'd1);
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: three commands, only two may be in flight
        divreq_rdy = 1'b1;
        send_cmd(1'b0, 1'b0, 32'h0000_0101, 32'd1, 5'd1);
        send_cmd(1'b0, 1'b1, 32'h0000_0102, 32'd2, 5'd2);
        send_cmd(1'b0, 1'b0, 32'h0000_0103, 32'd3, 5'd3);
        #1;
        chk("full_divreq_val", 65'(divreq_val), 65'd0);
        chk("full_cmd_rdy", 65'(cmd_rdy), 65'd0);
        chk("full_held_a", 65'(divreq_msg_a), 65'h103);
        chk("full_count", 65'(dut.fifo_count_s), 65'd2);
        tick();
        chk("full_divreq_val_hold", 65'(divreq_val), 65'd0);
        divresp_val = 1'b1;
        divresp_msg_result = {32'h11, 32'h10};
        #1;
        chk("full_divresp_rdy", 65'(divresp_rdy), 65'd1);
        tick();
        divresp_val = 1'b0;
        #1;
        chk("bp_wb1_tag", 65'(wb_tag), 65'd1);
        chk("bp_wb1_data", 65'(wb_data), 65'h10);
        chk("bp_third_issues", 65'(divreq_val), 65'd1);
        tick();
        chk("bp_third_gone", 65'(divreq_val), 65'd0);
        chk("bp_wb1_retired", 65'(wb_val), 65'd0);
        chk("bp_count2", 65'(dut.fifo_count_s), 65'd2);
        divresp_val = 1'b1;
        divresp_msg_result = {32'h21, 32'h20};
        tick();
        divresp_msg_result = {32'h31, 32'h30};
        chk("bp_wb2_tag", 65'(wb_tag), 65'd2);
        chk("bp_wb2_data", 65'(wb_data), 65'h21);
        tick();
        divresp_val = 1'b0;
        chk("bp_wb3_val", 65'(wb_val), 65'd1);
        chk("bp_wb3_tag", 65'(wb_tag), 65'd3);
        chk("bp_wb3_data", 65'(wb_data), 65'h30);
        tick();
        chk("bp_idle_wb", 65'(wb_val), 65'd0);
        chk("bp_idle_count", 65'(dut.fifo_count_s), 65'd0);

        // Writeback stall with two responses pending
        send_cmd(1'b1, 1'b0, 32'h0000_0404, 32'd4, 5'd4);
        send_cmd(1'b1, 1'b1, 32'h0000_0505, 32'd5, 5'd5);
        tick();
        divreq_rdy = 1'b0;
        wb_rdy = 1'b0;
        divresp_val = 1'b1;
        divresp_msg_result = {32'h44, 32'h40};
        tick();
        divresp_msg_result = {32'h55, 32'h50};
        #1;
        chk("stall_wb_tag", 65'(wb_tag), 65'd4);
        chk("stall_wb_data", 65'(wb_data), 65'h40);
        chk("stall_divresp_rdy", 65'(divresp_rdy), 65'd0);
        tick();
        tick();
        chk("stall_wb_tag_hold", 65'(wb_tag), 65'd4);
        chk("stall_wb_data_hold", 65'(wb_data), 65'h40);
        chk("stall_divresp_rdy_hold", 65'(divresp_rdy), 65'd0);
        chk("stall_count", 65'(dut.fifo_count_s), 65'd1);
        wb_rdy = 1'b1;
        #1;
        chk("stall_release_rdy", 65'(divresp_rdy), 65'd1);
        tick();
        divresp_val = 1'b0;
        chk("b2b_wb_val", 65'(wb_val), 65'd1);
        chk("b2b_wb_tag", 65'(wb_tag), 65'd5);
        chk("b2b_wb_data", 65'(wb_data), 65'h55);
        tick();
        chk("b2b_done", 65'(wb_val), 65'd0);
        chk("b2b_count", 65'(dut.fifo_count_s), 65'd0);

        // Unexpected response with nothing in flight
        divresp_val = 1'b1;
        divresp_msg_result = 64'h0000_0001_0000_0002;
        #1;
        chk("unexp_err_before", 65'(err), 65'd0);
        tick();
        divresp_val = 1'b0;
        wb_rdy = 1'b0;
        chk("unexp_err", 65'(err), 65'd1);
        chk("unexp_wb_tag", 65'(wb_tag), 65'd0);
        chk("unexp_wb_data", 65'(wb_data), 65'h2);
        tick();
        tick();
        chk("unexp_err_sticky", 65'(err), 65'd1);
        chk("unexp_wb_hold", 65'(wb_val), 65'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_err", 65'(err), 65'd0);
        chk("async_rst_wb_val", 65'(wb_val), 65'd0);
        tick();
        reset = 1'b0;
        wb_rdy = 1'b1;
        tick();

        // Reset while requests are in flight
        divreq_rdy = 1'b1;
        send_cmd(1'b0, 1'b0, 32'h0000_0606, 32'd6, 5'd6);
        send_cmd(1'b0, 1'b0, 32'h0000_0707, 32'd7, 5'd7);
        tick();
        divreq_rdy = 1'b0;
        wb_rdy = 1'b0;
        send_cmd(1'b0, 1'b0, 32'h0000_0808, 32'd8, 5'd8);
        divresp_val = 1'b1;
        divresp_msg_result = {32'h66, 32'h60};
        tick();
        divresp_val = 1'b0;
        chk("mid_pre_divreq_val", 65'(divreq_val), 65'd1);
        chk("mid_pre_wb_val", 65'(wb_val), 65'd1);
        chk("mid_pre_count", 65'(dut.fifo_count_s), 65'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_divreq_val", 65'(divreq_val), 65'd0);
        chk("mid_rst_wb_val", 65'(wb_val), 65'd0);
        chk("mid_rst_count", 65'(dut.fifo_count_s), 65'd0);
        chk("mid_rst_cmd_rdy", 65'(cmd_rdy), 65'd1);
        tick();
        reset = 1'b0;
        wb_rdy = 1'b1;
        tick();
        run_vec(vecs[1]);
        chk("final_err", 65'(err), 65'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imuldiv_div_requester.md
Name: imuldiv_div_requester

Overview:
- Initiator for the divider's divreq/divresp val/rdy interface: the pipeline-side client that issues divide requests and retires divide responses.
- Accepts tagged divide commands, drives the request port of an iterative divider, and tracks in-flight commands in a tag FIFO.
- Selects quotient or remainder from each 64-bit response and presents it on a tagged writeback port.
- Sits between the processor's execute stage and the iterative divider.

Parameters:
- TAG_W, 5, width of destination tag carried with each command
- MAX_OUT, 2, max in-flight requests (tag FIFO depth, power of two, >=1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_val  in  1  command valid
- cmd_rdy  out  1  command ready
- cmd_fn  in  1  1 = signed div/rem, 0 = unsigned
- cmd_rem  in  1  1 = return remainder, 0 = return quotient
- cmd_a  in  32  dividend
- cmd_b  in  32  divisor
- cmd_tag  in  TAG_W  destination tag
- divreq_msg_fn  out  1  to divider
- divreq_msg_a  out  32  to divider
- divreq_msg_b  out  32  to divider
- divreq_val  out  1  request valid
- divreq_rdy  in  1  request ready
- divresp_msg_result  in  64  {remainder[63:32], quotient[31:0]}
- divresp_val  in  1  response valid
- divresp_rdy  out  1  response ready
- wb_val  out  1  writeback valid
- wb_rdy  in  1  writeback ready
- wb_data  out  32  selected result
- wb_tag  out  TAG_W  tag of the retired command
- err  out  1  sticky: response arrived with no command in flight

Behaviour:
- Reset: clk is the single clock; reset is asynchronous, active-high. On reset assertion, immediately: request register empty (divreq_val=0), tag FIFO empty (count=0), writeback register empty (wb_val=0), err=0. Data registers reset to 0. Reset mid-operation drops all in-flight state; responses arriving after reset are handled as unexpected (see err).
- Request register (1 entry): holds fn, a, b, rem, tag. cmd_rdy = !req_full || (divreq_val && divreq_rdy && fifo_can_push). Command fire loads the register; divreq_val is asserted the next cycle, giving 1-cycle command-to-request latency. divreq_msg_* are driven directly from the register.
- Issue: divreq_val = req_full && (count < MAX_OUT). Request fire = divreq_val && divreq_rdy. It pushes {rem, tag} into the tag FIFO and clears or refills the register. divreq_msg_* and divreq_val must hold stable while unaccepted.
- Response: divresp_rdy = !wb_full || wb_rdy. Response fire = divresp_val && divresp_rdy. It loads the wb register: wb_data = fifo_head.rem ? result[63:32] : result[31:0]; wb_tag = head tag. It pops the FIFO and asserts wb_val the next cycle.
- Writeback: wb_val holds with stable data until wb_rdy. Retire and new-response load in the same cycle gives back-to-back throughput.
- Simultaneous push and pop in the same cycle: count is unchanged. Push is allowed when full only if a pop occurs in the same cycle (fifo_can_push = count<MAX_OUT || resp fire).
- FIFO pointers wrap modulo MAX_OUT. Count width is clog2(MAX_OUT)+1.
- Response fire with count==0: set err, no pop, wb still loads with tag 0 and the quotient. err clears only on reset.
- No combinational path from cmd_val to divreq_val. Paths from wb_rdy to divresp_rdy and from divreq_rdy to cmd_rdy are allowed.
- Responses return in issue order (the divider is in-order). No reordering logic.

Decomposition:
- Shared package/header: response field positions (REM_HI=63, REM_LO=32, QUO_HI=31, QUO_LO=0), FN_SIGNED=1 and FN_UNSIGNED=0 constants, and the divreq 65-bit packing order {fn, a, b}.
- One natural sub-module: imuldiv_tag_fifo, a parameterised-depth synchronous FIFO with full/empty/count and async reset. It is instantiated once.

Test Plan:
- Signed quotient: cmd fn=1, rem=0, a=0x00000222, b=0x0000002a, tag=3; a divider model returns 0x00000000_0000000d → wb_data=0x0000000d, wb_tag=3; divreq seen exactly 1 cycle after cmd fire with msg 65'h1_00000222_0000002a.
- Remainder select: cmd fn=1, rem=1, a=0xdeadbeef, b=0x0000beef; response 0xffffda72_ffffd353 → wb_data=0xffffda72. Repeat unsigned: fn=0, rem=0, a=0xfdec2897, b=0x00002266; response 0x00001d49_000761bd → wb_data=0x000761bd.
- Backpressure and full: hold divresp_val=0 and issue 3 commands with MAX_OUT=2 → only 2 divreq fires, the third held in the register with divreq_val=0 and cmd_rdy=0. Release one response → third issues in the same/next cycle; tags retire in order 1,2,3.
- Writeback stall: wb_rdy=0 with 2 responses pending → wb_data/wb_tag stable, divresp_rdy=0 after the first load. Set wb_rdy=1 → back-to-back retirement, 1 per cycle.
- Unexpected response: after reset, drive divresp_val with 0x00000001_00000002 and no command → err=1 and stays high. A subsequent reset clears err and wb_val asynchronously (checked mid-cycle).
- Reset mid-operation: assert reset while 2 requests are in flight → divreq_val, wb_val, and count go to 0 immediately without waiting for a clk edge. A new command after reset completes normally.
